// File: rtl/switch_matrix_cfg_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | switch_matrix_cfg_loader                                                    |
// | Framed, validated shadow/active config loader for a 5x4 routing matrix.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module switch_matrix_cfg_loader #(
   parameter  int N_TB = 5,
   parameter  int N_LR = 4,
   localparam int NENT = 2*N_TB + 2*N_LR
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [4:0]        cfg_addr,
   input  logic [5:0]        cfg_data,
   input  logic              cfg_last,
   input  logic              cfg_clear,
   output logic [NENT*6-1:0] cfg_active,
   output logic              busy,
   output logic              commit_done,
   output logic              err,
   output logic [1:0]        err_code
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_COMMIT = 2'd2,
      S_ABORT  = 2'd3
   } state_t;

   localparam logic [4:0] c_BOT_BASE   = 5'(N_TB);
   localparam logic [4:0] c_LEFT_BASE  = 5'(2*N_TB);
   localparam logic [4:0] c_RIGHT_BASE = 5'(2*N_TB + N_LR);
   localparam logic [4:0] c_NENT       = 5'(NENT);
   localparam logic [3:0] c_CNT_TB     = 4'(N_TB);
   localparam logic [3:0] c_CNT_LR     = 4'(N_LR);
   localparam logic [2:0] c_SIDE_NONE  = 3'd0;
   localparam logic [2:0] c_SIDE_TOP   = 3'd1;
   localparam logic [2:0] c_SIDE_RIGHT = 3'd2;
   localparam logic [2:0] c_SIDE_BOT   = 3'd3;
   localparam logic [2:0] c_SIDE_LEFT  = 3'd4;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [NENT*6-1:0]  r_shadow;
   logic [NENT*6-1:0]  r_active;
   logic               r_frame_err;
   logic               r_err;
   logic [1:0]         r_err_code;
   logic               r_commit_done;

   logic               w_ready;
   logic               w_acc;
   logic [2:0]         w_own_side;
   logic [4:0]         w_own_idx;
   logic [2:0]         w_src_side;
   logic [2:0]         w_src_idx;
   logic [3:0]         w_side_cnt;
   logic [1:0]         w_code;
   logic               w_bad;

   assign w_ready    = (r_state == S_IDLE) || (r_state == S_LOAD);
   // A same-cycle clear wins over any offered word.
   assign w_acc      = cfg_valid & w_ready & ~cfg_clear;
   assign w_src_side = cfg_data[2:0];
   assign w_src_idx  = cfg_data[5:3];

   always_comb begin
      w_own_side = c_SIDE_RIGHT;
      w_own_idx  = cfg_addr - c_RIGHT_BASE;
      if (cfg_addr < c_BOT_BASE) begin
         w_own_side = c_SIDE_TOP;
         w_own_idx  = cfg_addr;
      end else if (cfg_addr < c_LEFT_BASE) begin
         w_own_side = c_SIDE_BOT;
         w_own_idx  = cfg_addr - c_BOT_BASE;
      end else if (cfg_addr < c_RIGHT_BASE) begin
         w_own_side = c_SIDE_LEFT;
         w_own_idx  = cfg_addr - c_LEFT_BASE;
      end
   end

   always_comb begin
      w_side_cnt = 4'd0;
      case (w_src_side)
         c_SIDE_TOP, c_SIDE_BOT:    w_side_cnt = c_CNT_TB;
         c_SIDE_RIGHT, c_SIDE_LEFT: w_side_cnt = c_CNT_LR;
         default:                   w_side_cnt = 4'd0;
      endcase
   end

   always_comb begin
      w_code = 2'd0;
      if (cfg_addr >= c_NENT)
         w_code = 2'd1;
      else if (w_src_side > c_SIDE_LEFT)
         w_code = 2'd2;
      else if ((w_src_side != c_SIDE_NONE) && ({1'b0, w_src_idx} >= w_side_cnt))
         w_code = 2'd3;
      else if ((w_src_side != c_SIDE_NONE) && (w_src_side == w_own_side) &&
               ({2'b00, w_src_idx} == w_own_idx))
         w_code = 2'd3;
   end

   assign w_bad = (w_code != 2'd0);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_LOAD: begin
            if (cfg_clear)
               w_state_nxt = S_IDLE;
            else if (w_acc && cfg_last)
               w_state_nxt = (r_frame_err || w_bad) ? S_ABORT : S_COMMIT;
            else if (w_acc)
               w_state_nxt = S_LOAD;
         end
         S_COMMIT: w_state_nxt = S_IDLE;
         S_ABORT:  w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow      <= '0;
         r_active      <= '0;
         r_frame_err   <= 1'b0;
         r_err         <= 1'b0;
         r_err_code    <= 2'd0;
         r_commit_done <= 1'b0;
      end else begin
         r_err         <= 1'b0;
         r_commit_done <= (r_state == S_COMMIT);
         if (w_ready && cfg_clear) begin
            r_shadow    <= '0;
            r_active    <= '0;
            r_frame_err <= 1'b0;
         end else if (r_state == S_COMMIT) begin
            r_active    <= r_shadow;
            r_frame_err <= 1'b0;
         end else if (r_state == S_ABORT) begin
            // Discard partial frame so the next frame starts from the live config.
            r_shadow    <= r_active;
            r_frame_err <= 1'b0;
         end else if (w_acc) begin
            if (w_bad) begin
               r_err       <= 1'b1;
               r_err_code  <= w_code;
               r_frame_err <= 1'b1;
            end else begin
               for (int e = 0; e < NENT; e++) begin
                  if (cfg_addr == 5'(e))
                     r_shadow[e*6 +: 6] <= cfg_data;
               end
            end
         end
      end
   end

   assign cfg_ready   = w_ready;
   assign cfg_active  = r_active;
   assign busy        = (r_state != S_IDLE);
   assign commit_done = r_commit_done;
   assign err         = r_err;
   assign err_code    = r_err_code;

endmodule
`default_nettype wire
